// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared types and constants for the RV64M divide controller
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // in_op = {is_word, is_unsigned, is_rem}
  localparam int OP_REM  = 0;
  localparam int OP_UNS  = 1;
  localparam int OP_WORD = 2;

  localparam logic [2:0] OPC_DIV   = 3'b000;
  localparam logic [2:0] OPC_REM   = 3'b001;
  localparam logic [2:0] OPC_DIVU  = 3'b010;
  localparam logic [2:0] OPC_REMU  = 3'b011;
  localparam logic [2:0] OPC_DIVW  = 3'b100;
  localparam logic [2:0] OPC_REMW  = 3'b101;
  localparam logic [2:0] OPC_DIVUW = 3'b110;
  localparam logic [2:0] OPC_REMUW = 3'b111;

  // W ops divide the low word; signedness decides how it is widened for divu
  function automatic logic [63:0] extend_operand(input logic [2:0] op, input logic [63:0] v);
    logic [63:0] r;
    r = v;
    if (op[OP_WORD]) begin
      r = op[OP_UNS] ? {32'd0, v[31:0]} : {{32{v[31]}}, v[31:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/div_result_fmt.sv
// rtl/div_result_fmt.sv - quotient/remainder select with W-op sign extension
module div_result_fmt (
  input  logic        is_rem_i,
  input  logic        is_word_i,
  input  logic [63:0] quotient_i,
  input  logic [63:0] remainder_i,
  output logic [63:0] result_o
);

  logic [63:0] sel;

  assign sel      = is_rem_i ? remainder_i : quotient_i;
  assign result_o = is_word_i ? {{32{sel[31]}}, sel[31:0]} : sel;

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - issue/writeback controller for the iterative divider divu
// Optional macro DIV_CTRL_FASTPATH_EN: divide-by-zero answered locally without divu.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [63:0]      in_rs1,
  input  logic [63:0]      in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [63:0]      out_data,
  output logic             div_flush,
  output logic             div_valid,
  output logic             div_signed,
  output logic [63:0]      dividend,
  output logic [63:0]      divisor,
  input  logic [63:0]      quotient,
  input  logic [63:0]      remainder,
  input  logic             div_o_valid,
  output logic             div_o_ready
);

  state_e             state_q, state_d;
  logic [2:0]         op_q;
  logic [TAG_W-1:0]   tag_q;
  logic [63:0]        dividend_q, divisor_q, out_data_q;
  logic [63:0]        rs1_ext, rs2_ext, fmt_result, fast_result;
  logic               accept, take_result, go_fast;

  assign rs1_ext = extend_operand(in_op, in_rs1);
  assign rs2_ext = extend_operand(in_op, in_rs2);

  div_result_fmt u_fmt (
    .is_rem_i    (op_q[OP_REM]),
    .is_word_i   (op_q[OP_WORD]),
    .quotient_i  (quotient),
    .remainder_i (remainder),
    .result_o    (fmt_result)
  );

`ifdef DIV_CTRL_FASTPATH_EN
  div_result_fmt u_fast_fmt (
    .is_rem_i    (in_op[OP_REM]),
    .is_word_i   (in_op[OP_WORD]),
    .quotient_i  ('1),
    .remainder_i (rs1_ext),
    .result_o    (fast_result)
  );
  assign go_fast = (rs2_ext == 64'd0);
`else
  assign fast_result = '0;
  assign go_fast     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    div_valid   = 1'b0;
    div_o_ready = 1'b0;
    accept      = 1'b0;
    take_result = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = go_fast ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_valid = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        div_o_ready = 1'b1;
        if (div_o_valid) begin
          take_result = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush wins over everything, but the held operands are left untouched.
    if (flush) begin
      state_d     = S_IDLE;
      out_valid   = 1'b0;
      div_valid   = 1'b0;
      accept      = 1'b0;
      take_result = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= OPC_DIVU;
      tag_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= 64'd1;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= in_op;
        tag_q      <= in_tag;
        dividend_q <= rs1_ext;
        divisor_q  <= rs2_ext;
        if (go_fast) out_data_q <= fast_result;
      end
      if (take_result) out_data_q <= fmt_result;
    end
  end

  assign div_flush  = flush;
  assign div_signed = ~op_q[OP_UNS];
  assign dividend   = dividend_q;
  assign divisor    = divisor_q;
  assign out_data   = out_data_q;
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - randomized self-checking bench for div_ctrl with a behavioural divu
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam int TAG_W = 5;
`ifdef DIV_CTRL_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]       in_op;
  logic [63:0]      in_rs1, in_rs2, out_data, dividend, divisor, quotient, remainder;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic             div_flush, div_valid, div_signed, div_o_valid, div_o_ready;

  int vectors = 0;
  int miscompares = 0;

  div_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
    .div_flush(div_flush), .div_valid(div_valid), .div_signed(div_signed),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .div_o_valid(div_o_valid), .div_o_ready(div_o_ready)
  );

  always #5 clk = ~clk;

  // divu model: reads operands live, 1-cycle answer for div-by-zero or repeat, else 66 cycles
  function automatic logic [63:0] m_q(input logic [63:0] a, input logic [63:0] b, input logic s);
    if (b == 0) return '1;
    if (s && a == 64'h8000_0000_0000_0000 && b == '1) return a;
    if (s) return 64'($signed(a) / $signed(b));
    return a / b;
  endfunction

  function automatic logic [63:0] m_r(input logic [63:0] a, input logic [63:0] b, input logic s);
    if (b == 0) return a;
    if (s && a == 64'h8000_0000_0000_0000 && b == '1) return '0;
    if (s) return 64'($signed(a) % $signed(b));
    return a % b;
  endfunction

  assign quotient  = m_q(dividend, divisor, div_signed);
  assign remainder = m_r(dividend, divisor, div_signed);

  logic         m_busy, m_cache_v;
  int           m_cnt;
  logic [128:0] m_cache_key;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; div_o_valid <= 1'b0; m_cnt <= 0; m_cache_v <= 1'b0; m_cache_key <= '0;
    end else if (div_flush) begin
      m_busy <= 1'b0; div_o_valid <= 1'b0;
    end else if (div_o_valid && div_o_ready) begin
      div_o_valid <= 1'b0; m_busy <= 1'b0;
      m_cache_v <= 1'b1; m_cache_key <= {div_signed, dividend, divisor};
    end else if (div_valid && !m_busy) begin
      m_busy <= 1'b1;
      if (divisor == 0 || (m_cache_v && m_cache_key == {div_signed, dividend, divisor}))
        div_o_valid <= 1'b1;
      else
        m_cnt <= 65;
    end else if (m_busy && !div_o_valid) begin
      if (m_cnt <= 1) div_o_valid <= 1'b1;
      else m_cnt <= m_cnt - 1;
    end
  end

  // Reference: RV64M semantics computed directly, W ops on 32-bit values
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] x, y, r32;
    x = a[31:0];
    y = b[31:0];
    if (op[2]) begin
      if (y == 0) r32 = op[0] ? x : '1;
      else if (op[1]) r32 = op[0] ? x % y : x / y;
      else if (x == 32'h8000_0000 && y == '1) r32 = op[0] ? '0 : x;
      else r32 = op[0] ? 32'($signed(x) % $signed(y)) : 32'($signed(x) / $signed(y));
      return {{32{r32[31]}}, r32};
    end
    if (b == 0) return op[0] ? a : '1;
    if (op[1]) return op[0] ? a % b : a / b;
    if (a == 64'h8000_0000_0000_0000 && b == '1) return op[0] ? 64'd0 : a;
    return op[0] ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
  endfunction

  function automatic logic [63:0] ext(input logic [2:0] op, input logic [63:0] v);
    if (!op[2]) return v;
    if (op[1]) return {32'd0, v[31:0]};
    return {{32{v[31]}}, v[31:0]};
  endfunction

  logic         ref_cache_v = 1'b0;
  logic [128:0] ref_key = '0;

  function automatic int exp_lat(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    if (ext(op, b) == 0) return FAST ? 1 : 3;
    if (ref_cache_v && ref_key == {~op[1], ext(op, a), ext(op, b)}) return 3;
    return 68;
  endfunction

  function automatic int exp_pulses(input logic [2:0] op, input logic [63:0] b);
    return (FAST && ext(op, b) == 0) ? 0 : 1;
  endfunction

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return {$urandom(), $urandom()};
      1: return 64'($urandom_range(0, 20));
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return {$urandom(), 32'h8000_0000};
      default: return {32'hFFFF_FFFF, $urandom()};
    endcase
  endfunction

  // Presents one op from IDLE and returns once out_valid is seen (or the budget expires)
  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] tag, output logic [63:0] data,
                        output logic [TAG_W-1:0] otag, output int lat, output int pulses);
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag;
    lat = 0; pulses = 0;
    forever begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
      if (div_valid) pulses++;
      if (out_valid || lat >= 200) break;
    end
    data = out_data;
    otag = out_tag;
    if (!(FAST && ext(op, b) == 0)) begin
      ref_cache_v = 1'b1;
      ref_key = {~op[1], ext(op, a), ext(op, b)};
    end
  endtask

  task automatic release_resp();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    vectors += 9;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (div_valid !== 1'b0) begin miscompares++; $display("FAIL reset_div_valid: got %b expected 0", div_valid); end
    if (div_o_ready !== 1'b0) begin miscompares++; $display("FAIL reset_div_o_ready: got %b expected 0", div_o_ready); end
    if (out_data !== 64'd0) begin miscompares++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    if (out_tag !== '0) begin miscompares++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
    if (dividend !== 64'd0) begin miscompares++; $display("FAIL reset_dividend: got %h expected 0", dividend); end
    if (divisor !== 64'd1) begin miscompares++; $display("FAIL reset_divisor: got %h expected 1", divisor); end
    if (div_signed !== 1'b0) begin miscompares++; $display("FAIL reset_div_signed: got %b expected 0", div_signed); end
  endtask

  task automatic test_directed();
    logic [2:0]  ops[9]  = '{OPC_DIV, OPC_REM, OPC_DIVUW, OPC_DIVW, OPC_REMW, OPC_DIVU,
                             OPC_DIV, OPC_REM, OPC_DIVW};
    logic [63:0] as[9]   = '{-64'sd7, -64'sd7, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000,
                             64'h1234_0000_8000_0003, 64'h55, 64'h8000_0000_0000_0000,
                             64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000};
    logic [63:0] bs[9]   = '{64'd2, 64'd2, 64'd2, 64'd2, 64'd0, 64'd0, '1, '1, '1};
    logic [63:0] exps[9] = '{64'hFFFF_FFFF_FFFF_FFFD, '1, 64'h0000_0000_4000_0000,
                             64'hFFFF_FFFF_C000_0000, 64'hFFFF_FFFF_8000_0003, '1,
                             64'h8000_0000_0000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000};
    logic [63:0] data;
    logic [TAG_W-1:0] otag;
    int lat, pulses, elat;
    for (int i = 0; i < 9; i++) begin
      elat = exp_lat(ops[i], as[i], bs[i]);
      run_op(ops[i], as[i], bs[i], TAG_W'(i + 1), data, otag, lat, pulses);
      vectors += 4;
      if (data !== exps[i]) begin miscompares++; $display("FAIL directed_%0d_data: got %h expected %h", i, data, exps[i]); end
      if (otag !== TAG_W'(i + 1)) begin miscompares++; $display("FAIL directed_%0d_tag: got %h expected %h", i, otag, TAG_W'(i + 1)); end
      if (lat != elat) begin miscompares++; $display("FAIL directed_%0d_latency: got %0d expected %0d", i, lat, elat); end
      if (pulses != exp_pulses(ops[i], bs[i])) begin miscompares++; $display("FAIL directed_%0d_pulses: got %0d expected %0d", i, pulses, exp_pulses(ops[i], bs[i])); end
      release_resp();
    end
  endtask

  task automatic test_flush();
    logic [63:0] data;
    logic [TAG_W-1:0] otag;
    int lat, pulses;
    bit rose;
    rose = 1'b0;
    in_valid = 1'b1; in_op = OPC_DIVU; in_rs1 = 64'd1000001; in_rs2 = 64'd3; in_tag = 5'h03;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (out_valid) rose = 1'b1;
    end
    flush = 1'b1;
    #1;
    vectors++;
    if (div_flush !== 1'b1) begin miscompares++; $display("FAIL flush_div_flush: got %b expected 1", div_flush); end
    @(posedge clk); #1;
    flush = 1'b0;
    if (out_valid) rose = 1'b1;
    vectors += 2;
    if (rose) begin miscompares++; $display("FAIL flush_no_result: got out_valid 1 expected 0"); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    run_op(OPC_DIV, 64'd100, 64'd7, 5'h15, data, otag, lat, pulses);
    vectors += 3;
    if (data !== 64'd14) begin miscompares++; $display("FAIL flush_next_data: got %h expected %h", data, 64'd14); end
    if (otag !== 5'h15) begin miscompares++; $display("FAIL flush_next_tag: got %h expected 15", otag); end
    if (lat != 68) begin miscompares++; $display("FAIL flush_next_latency: got %0d expected 68", lat); end
    release_resp();
    // flush coinciding with in_valid drops the op
    in_valid = 1'b1; flush = 1'b1; in_op = OPC_DIV; in_rs1 = 64'd9; in_rs2 = 64'd4;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors += 2;
      if (div_valid !== 1'b0) begin miscompares++; $display("FAIL flush_drop_div_valid: got %b expected 0", div_valid); end
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_drop_in_ready: got %b expected 1", in_ready); end
      @(posedge clk); #1;
    end
    // flush in RESP beats out_ready
    run_op(OPC_REMU, 64'd77, 64'd5, 5'h07, data, otag, lat, pulses);
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; flush = 1'b0;
    vectors += 2;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_resp_out_valid: got %b expected 0", out_valid); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_resp_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_backpressure();
    logic [63:0] data, a, b;
    logic [TAG_W-1:0] otag;
    int lat, pulses;
    a = {$urandom(), $urandom()};
    b = 64'($urandom_range(1, 1000));
    run_op(OPC_DIVU, a, b, 5'h1A, data, otag, lat, pulses);
    vectors++;
    if (data !== ref_result(OPC_DIVU, a, b)) begin miscompares++; $display("FAIL bp_data: got %h expected %h", data, ref_result(OPC_DIVU, a, b)); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vectors += 4;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
      if (out_data !== data) begin miscompares++; $display("FAIL bp_out_data: got %h expected %h", out_data, data); end
      if (out_tag !== 5'h1A) begin miscompares++; $display("FAIL bp_out_tag: got %h expected 1a", out_tag); end
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    end
    release_resp();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] data, a, b, exp;
    logic [TAG_W-1:0] otag;
    int lat, pulses;
    a = {$urandom(), $urandom()};
    b = {$urandom(), 32'h0000_0101};
    exp = ref_result(OPC_DIV, a, b);
    for (int k = 0; k < 2; k++) begin
      run_op(OPC_DIV, a, b, TAG_W'(k + 8), data, otag, lat, pulses);
      vectors += 3;
      if (data !== exp) begin miscompares++; $display("FAIL b2b_%0d_data: got %h expected %h", k, data, exp); end
      if (otag !== TAG_W'(k + 8)) begin miscompares++; $display("FAIL b2b_%0d_tag: got %h expected %h", k, otag, TAG_W'(k + 8)); end
      if (lat != (k == 0 ? 68 : 3)) begin miscompares++; $display("FAIL b2b_%0d_latency: got %0d expected %0d", k, lat, (k == 0 ? 68 : 3)); end
      release_resp();
    end
  endtask

  task automatic test_random();
    logic [63:0] data, a, b, exp;
    logic [2:0] op;
    logic [TAG_W-1:0] otag, tag;
    int lat, pulses, elat;
    a = '0; b = '0;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      if (i == 0 || $urandom_range(0, 3) != 0) begin
        a = rnd_operand();
        b = ($urandom_range(0, 5) == 0) ? 64'd0 : rnd_operand();
      end
      tag = TAG_W'($urandom());
      exp = ref_result(op, a, b);
      elat = exp_lat(op, a, b);
      run_op(op, a, b, tag, data, otag, lat, pulses);
      vectors += 4;
      if (data !== exp) begin miscompares++; $display("FAIL rand_%0d_data op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, data, exp); end
      if (otag !== tag) begin miscompares++; $display("FAIL rand_%0d_tag: got %h expected %h", i, otag, tag); end
      if (lat != elat) begin miscompares++; $display("FAIL rand_%0d_latency: got %0d expected %0d", i, lat, elat); end
      if (pulses != exp_pulses(op, b)) begin miscompares++; $display("FAIL rand_%0d_pulses: got %0d expected %0d", i, pulses, exp_pulses(op, b)); end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      release_resp();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Issue/writeback controller for the 64-bit iterative divider `divu`; sits between the execute-stage dispatch and `divu`.
- Decodes the eight RV64M divide ops and extends 32-bit operands for W ops. Issues one request at a time to `divu` and holds its operands stable.
- Selects quotient or remainder, sign-extends W results and presents them downstream with a valid/ready handshake. Propagates pipeline flush to `divu`.

Parameters:
- TAG_W, 5, width of the destination-register tag carried alongside the op.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- flush  input  1  pipeline flush; kills any in-flight op
- in_valid  input  1  upstream op valid
- in_ready  output  1  controller can accept an op
- in_op  input  3  {is_word, is_unsigned, is_rem}
- in_rs1  input  64  dividend source
- in_rs2  input  64  divisor source
- in_tag  input  TAG_W  destination tag
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_tag  output  TAG_W  tag of result
- out_data  output  64  final RV64M result
- div_flush  output  1  equals flush
- div_valid  output  1  request pulse to `divu`
- div_signed  output  1  !is_unsigned of the held op
- dividend  output  64  extended rs1, held
- divisor  output  64  extended rs2, held
- quotient  input  64  from `divu`
- remainder  input  64  from `divu`
- div_o_valid  input  1  `divu` result valid
- div_o_ready  output  1  accept `divu` result

Behaviour:
- Reset values: in_ready=1, out_valid=0, div_valid=0, div_o_ready=0, out_data=0, out_tag=0, dividend=0, divisor=1, div_signed=0. State is IDLE.
- Operand extension at acceptance:
  - is_word & signed: sign-extend bits [31:0].
  - is_word & unsigned: zero-extend bits [31:0].
  - Otherwise pass through unchanged.
- States:
  - IDLE: in_ready=1. On in_valid, register op, tag and extended operands, then go to ISSUE.
  - ISSUE: div_valid=1 for exactly one cycle, then go to WAIT.
  - WAIT: div_o_ready=1. On div_o_valid, register the formatted result, then go to RESP.
  - RESP: out_valid=1. On out_ready, go to IDLE.
- in_ready is high only in IDLE, so no accept can coincide with a pending response.
- Result select: is_rem ? remainder : quotient. If is_word, sign-extend bit 31 of the selected value.
- Operand hold: dividend, divisor and div_signed must stay constant from ISSUE until the `divu` handshake. `divu` reads them live through its whole computation.
- Div-by-zero and signed overflow (MIN/-1) are passed through from `divu` unchanged; both already give RV64M-correct values after W formatting.
- Latency, with the accept cycle as T:
  - Normal division: out_valid first high at T+68.
  - `divu` result-cache hit or divisor==0: out_valid first high at T+3.
- Flush, in any state:
  - next state is IDLE; out_valid=0, div_valid=0.
  - held operands are kept.
  - a flush in the same cycle as in_valid drops the op.
  - a flush in RESP drops the result even if out_ready is high.
- out_valid is held with stable out_data/out_tag until out_ready (no retraction except flush).

Optional Feature:
- Macro DIV_CTRL_FASTPATH_EN.
- Defined:
  - in IDLE, an accepted op with extended divisor==0 skips `divu` and goes directly to RESP.
  - out_data is computed locally: all-ones for quotient, the extended dividend (W-formatted) for remainder.
  - latency T+1; no div_valid pulse.
- Undefined: every op goes through ISSUE and `divu`.

Decomposition:
- Package div_ctrl_pkg:
  - state encoding constants (IDLE/ISSUE/WAIT/RESP);
  - in_op bit-position constants (OP_REM=0, OP_UNS=1, OP_WORD=2);
  - op-name localparams for all 8 ops.
- One natural combinational sub-module, div_result_fmt: quotient/remainder select plus W sign-extension; reused by the fast path.

Test Plan:
- DIV rs1=-7, rs2=2 -> out_data=0xFFFFFFFFFFFFFFFD at T+68; REM same operands -> 0xFFFFFFFFFFFFFFFF.
- DIVUW rs1=0xFFFFFFFF_80000000, rs2=2 -> out_data=0x0000000040000000; DIVW same operands -> 0xFFFFFFFFC0000000.
- REMW rs1=0x1234_0000_8000_0003, rs2=0 -> out_data=0xFFFFFFFF80000003; DIVU rs2=0 -> all ones. Latency T+3 without the macro, T+1 with it.
- DIV rs1=0x8000000000000000, rs2=-1 -> quotient 0x8000000000000000, REM -> 0; DIVW rs1=0x80000000, rs2=-1 -> 0xFFFFFFFF80000000.
- Flush at T+30 of a DIVU -> out_valid never rises. Next op 100/7 issued in the following cycle -> 14 with the correct tag.
- out_ready held low 10 cycles in RESP -> out_valid/out_data/out_tag stable and in_ready=0 throughout. Back-to-back identical ops -> the second result arrives via the `divu` cache at T+3.
